// File: rtl/scope_sequencer.sv
// Purpose: arm/trigger/capture a DEPTH x 32 sample frame, then stream it to a UART as HDR + 4*DEPTH bytes.
// Latency: trigger sample stored on the edge it arrives; the first tx_start appears 1 cycle after entering SEND (tx_busy low).
// Backpressure: each byte waits for tx_busy low after a blanking cycle; samples arriving outside ARMED/CAPTURE are dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   arm, abort        start a capture (IDLE only) / return to IDLE from anywhere (wins over arm and trigger)
//   force_trig        trigger on the next valid sample while ARMED
//   trig_level        unsigned rising-edge threshold on sample[15:0]
//   sample_valid, sample  ADC word strobe and data
//   tx_busy           UART transmitter busy
//   tx_start, tx_data one-cycle launch pulse and byte (held until the byte completes)
//   busy, done, state status: not-IDLE, end-of-frame pulse, encoded state
module scope_sequencer #(
  parameter int unsigned DEPTH = 16,
  parameter logic [7:0]  HDR   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        abort,
  input  logic        force_trig,
  input  logic [15:0] trig_level,
  input  logic        sample_valid,
  input  logic [31:0] sample,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND    = 3'd3
  } state_e;

  // Byte handshake phases inside SEND:
  //   ISSUE - waiting to launch the header byte
  //   START - tx_start is high this cycle
  //   BLANK - tx_busy is ignored (transmitter may not have raised it yet)
  //   WAIT  - first cycle with tx_busy low completes the byte
  typedef enum logic [1:0] {
    P_ISSUE = 2'd0,
    P_START = 2'd1,
    P_BLANK = 2'd2,
    P_WAIT  = 2'd3
  } phase_e;

  state_e        state_q, state_d;
  phase_e        ph_q, ph_d;
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [1:0]    bc_q, bc_d;
  logic          hdr_q, hdr_d;
  logic [15:0]   prev_q, prev_d;
  logic          prev_ok_q, prev_ok_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          done_q, done_d;

  logic [31:0]   mem_q [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;

  logic          level_trig;
  logic [AW-1:0] rp_nxt;
  logic [31:0]   word_cur;
  logic [31:0]   word_nxt;

  // Lane 3 is the most significant byte, sent first.
  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] b);
    logic [7:0] r;
    case (b)
      2'd3:    r = w[31:24];
      2'd2:    r = w[23:16];
      2'd1:    r = w[15:8];
      default: r = w[7:0];
    endcase
    return r;
  endfunction

  assign level_trig = prev_ok_q && (prev_q < trig_level) && (sample[15:0] >= trig_level);
  assign rp_nxt     = rp_q + 1'b1;
  assign word_cur   = mem_q[rp_q];
  assign word_nxt   = mem_q[rp_nxt];

  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    bc_d       = bc_q;
    hdr_d      = hdr_q;
    prev_d     = prev_q;
    prev_ok_d  = prev_ok_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    we         = 1'b0;
    waddr      = wp_q;

    if (abort) begin
      // An interrupted frame is discarded; a byte already launched simply finishes on the wire.
      state_d   = S_IDLE;
      ph_d      = P_ISSUE;
      wp_d      = '0;
      rp_d      = '0;
      bc_d      = 2'd0;
      hdr_d     = 1'b0;
      prev_ok_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_d   = S_ARMED;
            wp_d      = '0;
            rp_d      = '0;
            prev_ok_d = 1'b0;
          end
        end

        S_ARMED: begin
          if (sample_valid) begin
            prev_d    = sample[15:0];
            prev_ok_d = 1'b1;
            if (level_trig || force_trig) begin
              we      = 1'b1;
              waddr   = '0;
              wp_d    = AW'(1);
              state_d = S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            we    = 1'b1;
            waddr = wp_q;
            if (wp_q == LAST) begin
              wp_d    = '0;
              state_d = S_SEND;
              ph_d    = P_ISSUE;
              hdr_d   = 1'b1;
              rp_d    = '0;
              bc_d    = 2'd0;
            end else begin
              wp_d = wp_q + 1'b1;
            end
          end
        end

        S_SEND: begin
          case (ph_q)
            P_ISSUE: begin
              if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = hdr_q ? HDR : lane(word_cur, bc_q);
                ph_d       = P_START;
              end
            end
            P_START: ph_d = P_BLANK;
            P_BLANK: ph_d = P_WAIT;
            default: begin
              // Completion edge: launch the next byte directly so the byte period can be 3 cycles.
              if (!tx_busy) begin
                if (hdr_q) begin
                  hdr_d      = 1'b0;
                  bc_d       = 2'd3;
                  tx_start_d = 1'b1;
                  tx_data_d  = lane(word_cur, 2'd3);
                  ph_d       = P_START;
                end else if (bc_q != 2'd0) begin
                  bc_d       = bc_q - 2'd1;
                  tx_start_d = 1'b1;
                  tx_data_d  = lane(word_cur, bc_q - 2'd1);
                  ph_d       = P_START;
                end else if (rp_q == LAST) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
                  ph_d    = P_ISSUE;
                  rp_d    = '0;
                end else begin
                  rp_d       = rp_nxt;
                  bc_d       = 2'd3;
                  tx_start_d = 1'b1;
                  tx_data_d  = lane(word_nxt, 2'd3);
                  ph_d       = P_START;
                end
              end
            end
          endcase
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ph_q       <= P_ISSUE;
      wp_q       <= '0;
      rp_q       <= '0;
      bc_q       <= 2'd0;
      hdr_q      <= 1'b0;
      prev_q     <= 16'h0000;
      prev_ok_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      bc_q       <= bc_d;
      hdr_q      <= hdr_d;
      prev_q     <= prev_d;
      prev_ok_q  <= prev_ok_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  // Sample storage has no reset; contents are only meaningful after a full capture.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem_q[waddr] <= sample;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;

endmodule

// File: tb/tb_scope_sequencer.sv
module tb_scope_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        arm;
  logic        abort;
  logic        force_trig;
  logic [15:0] trig_level;
  logic        sample_valid;
  logic [31:0] sample;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic [2:0]  state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scope_sequencer #(.DEPTH(16), .HDR(8'hA5)) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .force_trig   (force_trig),
    .trig_level   (trig_level),
    .sample_valid (sample_valid),
    .sample       (sample),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .done         (done),
    .state        (state)
  );

  // UART model: busy for 10 cycles after each tx_start, records every byte launched.
  logic [7:0] txb [0:1023];
  int         n_start    = 0;
  int         bcnt       = 0;
  logic [7:0] held       = 8'h00;
  int         cyc        = 0;
  int         last_start = -100;
  int         stab_viol  = 0;
  int         gap_viol   = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_start) begin
      if (n_start < 1024) txb[n_start] <= tx_data;
      n_start    <= n_start + 1;
      if (cyc - last_start < 3) gap_viol <= gap_viol + 1;
      last_start <= cyc;
      held       <= tx_data;
      bcnt       <= 10;
      tx_busy    <= 1'b1;
    end else if (bcnt > 0) begin
      if (tx_data != held) stab_viol <= stab_viol + 1;
      bcnt <= bcnt - 1;
      if (bcnt == 1) tx_busy <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic put(input logic [31:0] v);
    sample       = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  // Force-trigger a capture and fill the rest of the buffer with first_word, then k=1..15 tagged words.
  task automatic fill_frame(input logic [31:0] first_word, input logic [31:0] tagw);
    force_trig = 1'b1;
    put(first_word);
    force_trig = 1'b0;
    for (int k = 1; k <= 15; k++) put(tagw | 32'(k));
  endtask

  int base;
  int k5;
  int late_starts;
  int late_dones;

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
    sample_valid = 1'b0; sample = 32'd0; trig_level = 16'd1000;
    repeat (2) @(negedge clk);
    chk("rst_state",    {29'd0, state}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("rst_busy",     {31'd0, busy}, 32'd0);
    chk("rst_done",     {31'd0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Level trigger, full frame with slow transmitter.
    base = n_start;
    pulse_arm();
    chk("t1_armed", {29'd0, state}, 32'd1);
    chk("t1_busy",  {31'd0, busy}, 32'd1);
    put(32'd900);
    chk("t1_no_trig_900", {29'd0, state}, 32'd1);
    put(32'd1100);
    chk("t1_trig_1100", {29'd0, state}, 32'd2);
    for (int k = 1; k <= 14; k++) put(32'hC0DE0000 | 32'(k));
    chk("t1_still_capture", {29'd0, state}, 32'd2);
    put(32'hC0DE000F);
    chk("t1_send", {29'd0, state}, 32'd3);
    put(32'hDEADBEEF);
    wait_done(3000, "t1_done_seen");
    chk("t1_idle_at_done", {29'd0, state}, 32'd0);
    chk("t1_notbusy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
    @(negedge clk);
    chk("t1_byte_count", n_start - base, 32'd65);
    chk("t1_hdr",   {24'd0, txb[base]},      32'hA5);
    chk("t1_b1",    {24'd0, txb[base + 1]},  32'h00);
    chk("t1_b2",    {24'd0, txb[base + 2]},  32'h00);
    chk("t1_b3",    {24'd0, txb[base + 3]},  32'h04);
    chk("t1_b4",    {24'd0, txb[base + 4]},  32'h4C);
    chk("t1_b5",    {24'd0, txb[base + 5]},  32'hC0);
    chk("t1_b8",    {24'd0, txb[base + 8]},  32'h01);
    chk("t1_b61",   {24'd0, txb[base + 61]}, 32'hC0);
    chk("t1_b63",   {24'd0, txb[base + 63]}, 32'h00);
    chk("t1_b64",   {24'd0, txb[base + 64]}, 32'h0F);
    chk("t1_gap",   gap_viol, 32'd0);
    chk("t1_txdata_stable", stab_viol, 32'd0);

    // First-sample guard, then abort from CAPTURE.
    pulse_arm();
    put(32'd2000);
    chk("t2_first_no_trig", {29'd0, state}, 32'd1);
    put(32'd500);
    chk("t2_500_no_trig", {29'd0, state}, 32'd1);
    put(32'd1500);
    chk("t2_trig_1500", {29'd0, state}, 32'd2);
    pulse_abort();
    chk("t2_abort_idle", {29'd0, state}, 32'd0);
    chk("t2_abort_busy", {31'd0, busy}, 32'd0);

    // force_trig needs a sample, and triggers on the first one.
    pulse_arm();
    force_trig = 1'b1;
    @(negedge clk);
    chk("t3_force_needs_sample", {29'd0, state}, 32'd1);
    put(32'd10);
    force_trig = 1'b0;
    chk("t3_force_first", {29'd0, state}, 32'd2);
    pulse_abort();

    // Coincident events: abort wins.
    arm = 1'b1; abort = 1'b1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    chk("t4_arm_abort_idle", {29'd0, state}, 32'd0);
    pulse_arm();
    abort = 1'b1; force_trig = 1'b1; sample = 32'd5000; sample_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; force_trig = 1'b0; sample_valid = 1'b0;
    chk("t4_abort_over_trig", {29'd0, state}, 32'd0);

    // Abort after the 5th byte of SEND.
    pulse_arm();
    fill_frame(32'h12345678, 32'h55000000);
    chk("t5_send", {29'd0, state}, 32'd3);
    k5 = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (tx_start) k5++;
      if (k5 == 5) break;
    end
    chk("t5_fifth_byte_seen", k5, 32'd5);
    pulse_abort();
    chk("t5_abort_state", {29'd0, state}, 32'd0);
    chk("t5_abort_busy",  {31'd0, busy}, 32'd0);
    late_starts = 0;
    late_dones  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_start) late_starts++;
      if (done) late_dones++;
    end
    chk("t5_no_tx_after_abort",   late_starts, 32'd0);
    chk("t5_no_done_after_abort", late_dones, 32'd0);

    // arm ignored during SEND; re-arm after done.
    base = n_start;
    pulse_arm();
    fill_frame(32'hCAFEF00D, 32'h66000000);
    repeat (20) @(negedge clk);
    pulse_arm();
    chk("t6_arm_ignored_send", {29'd0, state}, 32'd3);
    wait_done(3000, "t6_done_seen");
    repeat (2) @(negedge clk);
    chk("t6_byte_count", n_start - base, 32'd65);
    chk("t6_b1", {24'd0, txb[base + 1]}, 32'hCA);
    chk("t6_b4", {24'd0, txb[base + 4]}, 32'h0D);
    pulse_arm();
    chk("t6_rearm", {29'd0, state}, 32'd1);
    pulse_abort();

    // Reset after 7 stored samples, then a clean capture.
    pulse_arm();
    force_trig = 1'b1;
    put(32'hAAAA0000);
    force_trig = 1'b0;
    for (int k = 1; k <= 6; k++) put(32'hAAAA0000 | 32'(k));
    chk("t7_capturing", {29'd0, state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7_rst_state",    {29'd0, state}, 32'd0);
    chk("t7_rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("t7_rst_tx_data",  {24'd0, tx_data}, 32'd0);
    chk("t7_rst_busy",     {31'd0, busy}, 32'd0);
    chk("t7_rst_done",     {31'd0, done}, 32'd0);
    base = n_start;
    pulse_arm();
    chk("t7_rearm", {29'd0, state}, 32'd1);
    force_trig = 1'b1;
    put(32'h11223344);
    force_trig = 1'b0;
    for (int k = 1; k <= 14; k++) put(32'h77000000 | 32'(k));
    chk("t7_wp_restart", {29'd0, state}, 32'd2);
    put(32'h7700000F);
    chk("t7_send", {29'd0, state}, 32'd3);
    wait_done(3000, "t7_done_seen");
    repeat (2) @(negedge clk);
    chk("t7_byte_count", n_start - base, 32'd65);
    chk("t7_b1", {24'd0, txb[base + 1]}, 32'h11);
    chk("t7_b2", {24'd0, txb[base + 2]}, 32'h22);
    chk("t7_b3", {24'd0, txb[base + 3]}, 32'h33);
    chk("t7_b4", {24'd0, txb[base + 4]}, 32'h44);
    chk("t7_b64", {24'd0, txb[base + 64]}, 32'h0F);
    chk("all_gap", gap_viol, 32'd0);
    chk("all_txdata_stable", stab_viol, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
